// File: rtl/mux_sel_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arb_pkg
// Brief    : Shared types and constants for the mux select arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_sel_arb_pkg;

  localparam int DEFAULT_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_sel_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_beat_cnt
// Brief    : Loadable down-counter tracking remaining beats of a grant.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_beat_cnt
  import mux_sel_arb_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic [LEN_W-1:0] o_beats_left
);

  logic [LEN_W-1:0] r_count;

  // Load wins over decrement so a handover ack reloads instead of counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero       = (r_count == '0);
  assign o_beats_left = r_count;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Brief    : Two-requester round-robin burst arbiter driving a registered
//            2:1 mux select. Optional watchdog: MUX_SEL_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
  import mux_sel_arb_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W,
  parameter int TO_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [LEN_W-1:0] len_a,
  input  logic [LEN_W-1:0] len_b,
  input  logic             ack,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic [LEN_W-1:0] beats_left,
  output logic             timeout
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_sel;
  logic             r_last;
  logic             w_own;
  logic             w_release;
  logic             w_arbitrate;
  logic             w_grant;
  logic             w_pick_b;
  logic             w_load;
  logic [LEN_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_cnt_zero;
  logic             w_wd_fire;

  function automatic logic [LEN_W-1:0] len_to_left(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign w_own       = (r_state != IDLE);
  assign w_release   = w_own && ((ack && w_cnt_zero) || w_wd_fire);
  assign w_arbitrate = !w_own || w_release;
  assign w_grant     = w_arbitrate && (req_a || req_b);
  // While owning x, last == x, so "prefer not-last" also yields the
  // end-of-burst rule: other first, then re-grant own, else idle.
  assign w_pick_b    = (req_a && req_b) ? (r_last == SEL_A) : req_b;
  assign w_dec       = w_own && ack && !w_cnt_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    if (w_arbitrate) begin
      if (w_grant) begin
        w_state_nxt = w_pick_b ? OWN_B : OWN_A;
        w_load      = 1'b1;
        w_load_val  = w_pick_b ? len_to_left(len_b) : len_to_left(len_a);
      end else begin
        w_state_nxt = IDLE;
        w_load      = w_own;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= SEL_A;
      r_last  <= SEL_B;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_sel  <= w_pick_b ? SEL_B : SEL_A;
        r_last <= w_pick_b ? SEL_B : SEL_A;
      end
    end
  end

  mux_sel_beat_cnt #(
    .LEN_W (LEN_W)
  ) u_beat_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .i_dec        (w_dec),
    .o_zero       (w_cnt_zero),
    .o_beats_left (beats_left)
  );

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
  localparam logic [TO_W-1:0] c_wd_pre_max = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] r_wd;
  logic            r_timeout;

  // Fires on the edge where the stall count would reach all-ones.
  assign w_wd_fire = w_own && !ack && (r_wd == c_wd_pre_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_fire;
      if (w_grant || ack) begin
        r_wd <= '0;
      end else if (w_own) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign sel   = r_sel;
  assign gnt_a = (r_state == OWN_A);
  assign gnt_b = (r_state == OWN_B);
  assign busy  = gnt_a | gnt_b;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Brief    : Scoreboard bench for mux_sel_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int LEN_W = 4;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
  localparam int TO_W = 3;
`else
  localparam int TO_W = 6;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_a = 1'b0;
  logic             req_b = 1'b0;
  logic [LEN_W-1:0] len_a = '0;
  logic [LEN_W-1:0] len_b = '0;
  logic             ack = 1'b0;
  logic             sel, gnt_a, gnt_b, busy, timeout;
  logic [LEN_W-1:0] beats_left;

  mux_sel_arbiter #(.LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .len_a      (len_a),
    .len_b      (len_b),
    .ack        (ack),
    .sel        (sel),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .busy       (busy),
    .beats_left (beats_left),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sel;
    logic             gnt_a;
    logic             gnt_b;
    logic             busy;
    logic [LEN_W-1:0] bl;
    logic             to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: owner 0=none 1=A 2=B; rem = acks still needed to finish the burst.
  int m_owner, m_rem, m_last, m_stall;
  logic m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_rem = 0; m_last = 2; m_stall = 0; m_sel = 1'b0;
  endtask

  function automatic exp_t model_out(input logic to);
    exp_t e;
    e.sel   = m_sel;
    e.gnt_a = (m_owner == 1);
    e.gnt_b = (m_owner == 2);
    e.busy  = (m_owner != 0);
    e.bl    = (m_owner != 0) ? LEN_W'(m_rem - 1) : '0;
    e.to    = to;
    return e;
  endfunction

  // Called aligned to a falling edge: drive, predict the next rising edge, wait.
  task automatic step(input logic ra, input logic rb, input int la, input int lb, input logic ak);
    logic rel = 1'b0;
    logic to  = 1'b0;
    int   pick = 0;
    req_a = ra; req_b = rb; len_a = LEN_W'(la); len_b = LEN_W'(lb); ack = ak;
    if (m_owner != 0) begin
      if (ak) begin
        m_stall = 0;
        if (m_rem == 1) rel = 1'b1;
        else m_rem--;
      end else begin
        m_stall++;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        if (m_stall == (1 << TO_W) - 1) begin rel = 1'b1; to = 1'b1; end
`endif
      end
    end
    if (m_owner == 0 || rel) begin
      if (ra && rb)  pick = (m_last == 1) ? 2 : 1;
      else if (ra)   pick = 1;
      else if (rb)   pick = 2;
      m_owner = pick;
      if (pick != 0) begin
        m_rem   = (pick == 1) ? ((la % 16 == 0) ? 1 : la % 16) : ((lb % 16 == 0) ? 1 : lb % 16);
        m_last  = pick;
        m_sel   = (pick == 2);
        m_stall = 0;
      end
    end
    exp_q.push_back(model_out(to));
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel",  {31'd0, sel},   32'd0);
    check("async_rst_busy", {31'd0, busy},  32'd0);
    check("async_rst_gnt",  {30'd0, gnt_a, gnt_b}, 32'd0);
    check("async_rst_bl",   {28'd0, beats_left}, 32'd0);
    model_reset();
    req_a = 1'b0; req_b = 1'b0; ack = 1'b0;
    exp_q.push_back(model_out(1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sel",        {31'd0, sel},        {31'd0, e.sel});
        check("gnt_a",      {31'd0, gnt_a},      {31'd0, e.gnt_a});
        check("gnt_b",      {31'd0, gnt_b},      {31'd0, e.gnt_b});
        check("busy",       {31'd0, busy},       {31'd0, e.busy});
        check("beats_left", {28'd0, beats_left}, {28'd0, e.bl});
        check("timeout",    {31'd0, timeout},    {31'd0, e.to});
      end
    end
  end

  initial begin : stimulus
    model_reset();
    #1;
    check("reset_sel",  {31'd0, sel},  32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_bl",   {28'd0, beats_left}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single A burst of 3 with continuous ack, then idle holding sel.
    step(1, 0, 3, 0, 1);
    repeat (5) step(0, 0, 3, 0, 1);

    // Both requesting from reset with length 2: A,A,B,B,A,A...
    reset_mid();
    repeat (10) step(1, 1, 2, 2, 1);
    repeat (3) step(0, 0, 2, 2, 1);

    // Zero length on B gives a single-beat grant.
    step(0, 1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // Request dropped after the first beat of a 4-beat burst.
    step(1, 0, 4, 0, 0);
    repeat (6) step(0, 0, 4, 0, 1);

    // Reset mid-burst at beats_left=2, then A wins the next tie.
    step(1, 0, 4, 0, 0);
    step(1, 0, 4, 0, 1);
    reset_mid();
    repeat (4) step(1, 1, 2, 2, 1);
    repeat (2) step(0, 0, 2, 2, 1);

    // Stalled A with B waiting (watchdog release when compiled in).
    step(1, 0, 4, 0, 0);
    repeat (9) step(0, 1, 4, 2, 0);
    repeat (4) step(0, 0, 4, 2, 1);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) reset_mid();
      else step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-requester round-robin burst arbiter that generates the `sel` input of the 2:1 gate-level multiplexer stage directly downstream. Source A is routed when `sel`=0 and source B when `sel`=1. A grant is held for a programmed number of accepted beats, then re-arbitrated. `sel` is registered so the mux data path sees a glitch-free select.

## Interface
Parameters:
- `LEN_W`, default 4: width of burst-length inputs and beat counter.
- `TO_W`, default 6: watchdog counter width; used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_a`  in  1  source A requests the mux.
- `req_b`  in  1  source B requests the mux.
- `len_a`  in  LEN_W  beats in A's burst, sampled at grant; 0 is treated as 1.
- `len_b`  in  LEN_W  beats in B's burst, same rule.
- `ack`  in  1  consumer accepted one beat from the mux output `y`.
- `sel`  out  1  mux select; 0 routes a, 1 routes b.
- `gnt_a`  out  1  A owns the mux.
- `gnt_b`  out  1  B owns the mux.
- `busy`  out  1  a grant is active.
- `beats_left`  out  LEN_W  remaining beats minus one in the current grant.
- `timeout`  out  1  one-cycle pulse on watchdog release; constant 0 without the macro.

## Operation
- FSM states: IDLE, OWN_A, OWN_B. Encoding comes from the package.
- Priority pointer `last`: reset value B, so A wins the first tie.
- IDLE:
  - `req_a` only → OWN_A.
  - `req_b` only → OWN_B.
  - Both → grant the requester that is not `last`.
  - Neither → stay in IDLE.
- On entry to OWN_x:
  - `beats_left` ← `len_x`−1, or 0 if `len_x`=0.
  - `sel` ← x.
  - `last` ← x.
- In OWN_x:
  - `ack` with `beats_left`>0 → decrement.
  - `ack` with `beats_left`=0 → burst ends and arbitration happens in the same cycle:
    - Other requester asserted → grant the other.
    - Otherwise, own request still asserted → re-grant x with a fresh length.
    - Otherwise → IDLE.
- Deasserting `req_x` mid-burst does not release the grant; only burst completion or timeout releases it.
- In IDLE, `sel` holds its last value. It never changes without a grant change.
- `gnt_a`/`gnt_b` are one-hot or both zero. `busy` = `gnt_a` | `gnt_b`.
- Reset values: `sel`=0, `gnt_a`=0, `gnt_b`=0, `busy`=0, `beats_left`=0, `timeout`=0, state IDLE.

## Timing
- Request to grant: 1 cycle. A request sampled at edge N gives a grant visible after edge N.
- `sel`, `gnt_*`, `beats_left` are all registered and change on the same edge.
- Back-to-back handover: the final `ack` at edge N switches `sel` at edge N, with no idle bubble.
- A new request arriving on the same cycle as the final `ack` is considered in that arbitration.
- An `ack` while in IDLE is ignored.
- Asserting `rst` forces reset values immediately, independent of `clk`, and aborts any burst.
- The first arbitration after `rst` deasserts happens on the next rising edge.

## Configuration
- Macro `MUX_SEL_ARBITER_TIMEOUT_EN`.
- Defined:
  - A TO_W-bit watchdog clears on grant entry and on every `ack`, and increments each cycle in OWN_x without `ack`.
  - When it reaches all-ones, the grant is released as if the burst completed, using the normal arbitration rules. `timeout` pulses for 1 cycle.
- Undefined:
  - No watchdog logic is built and `timeout` is tied to 0.
  - A grant is held until its burst completes.

## Structure
- Package `mux_sel_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, OWN_A, OWN_B);
  - constants `SEL_A`=1'b0 and `SEL_B`=1'b1;
  - the default `LEN_W`.
- Sub-module `mux_sel_beat_cnt` is a loadable down-counter. It has load, decrement, zero flag and `beats_left` output, and is instantiated once.
- The FSM, priority pointer and optional watchdog live in the top module.

## Test plan
- Reset, then `req_a`=1, `len_a`=3, `ack` every cycle → `gnt_a`=1 and `sel`=0 one cycle after the request, held for exactly 3 acks, then IDLE with `sel` still 0.
- `req_a`=`req_b`=1 from reset, `len_a`=`len_b`=2, continuous `ack` → grants A,A,B,B,A,A…, with `sel` toggling every 2 beats and no bubble.
- `len_b`=0, only `req_b` → a single-beat grant; `sel`=1 for 1 ack cycle.
- `req_a` dropped after the 1st beat of a 4-beat burst → grant held until the 4th `ack`.
- `rst` pulsed mid-burst at `beats_left`=2 → all outputs return to reset values asynchronously. The next grant after deassertion goes to A.
- With `MUX_SEL_ARBITER_TIMEOUT_EN` and `TO_W`=3, grant A and hold `ack`=0 → `timeout` pulses 7 cycles after grant entry, and B, if requesting, is granted on that same edge.
